dec_hazard_ctrl: RTL
====================

// Module: dec_hazard_ctrl
// PURPOSE
//  Interlock controller that sequences the decode stage. A per-register scoreboard tracks
//  destinations of loads issued to EXEC but not yet written back. It stalls decode on
//  RAW/WAW hazards and when the outstanding-load budget is full, and sequences a fixed
//  flush window after a jump. Sits beside decode: stall_o gates the decode/fetch ready path,
//  and flush_o qualifies the NOP insertion.
// PARAMETERS
//  NUM_REGS   32  architectural registers tracked (x0 never tracked)
//  MAX_PEND   4   max outstanding loads awaiting writeback (>=1)
//  FLUSH_CYC  1   flush cycles held after the jump cycle (>=1)
// PORTS
//  clk              in   1          clock
//  rst              in   1          reset, synchronous, active-high
//  fetch_valid_i    in   1          instruction at decode input is valid
//  fetch_rs1_i      in   5          rs1 of decoding instruction
//  fetch_rs2_i      in   5          rs2 of decoding instruction
//  fetch_rd_i       in   5          rd of decoding instruction
//  fetch_use_rs1_i  in   1          instruction reads rs1
//  fetch_use_rs2_i  in   1          instruction reads rs2
//  fetch_we_i       in   1          instruction writes rd
//  fetch_ld_i       in   1          instruction is a load
//  issue_i          in   1          decode->exec handshake fired this cycle
//  issue_rd_i       in   5          rd of issued instruction
//  issue_ld_i       in   1          issued instruction is a load writing rd
//  wb_we_i          in   1          writeback to register file this cycle
//  wb_rd_i          in   5          writeback destination
//  jump_i           in   1          redirect from EXEC
//  stall_o          out  1          hold decode (deassert ready to fetch)
//  flush_o          out  1          decode must emit NOP / drop instruction
//  pend_cnt_o       out  $clog2(MAX_PEND+1)  outstanding loads
//  sb_o             out  NUM_REGS   scoreboard (bit i = xi pending)
//  state_o          out  2          FSM state: 0 RUN, 1 STALL, 2 FLUSH
// BEHAVIOUR
//  - Reset (sync): sb=0, pend_cnt=0, state=RUN, flush counter=0. stall_o and flush_o are forced
//    0 while rst is high. Otherwise stall_o, flush_o, pend_cnt_o, and sb_o are 0 out of reset.
//  - Effective sb for the hazard check: sb_ff & ~(wb_we_i ? onehot(wb_rd_i) : 0).
//    A same-cycle writeback releases the stall (zero-cycle bypass).
//  - hazard = fetch_valid_i & ((use_rs1&sbE[rs1]) | (use_rs2&sbE[rs2]) | (we&sbE[rd]) |
//    (fetch_ld_i & pend_cnt==MAX_PEND & ~wb_release)). Index 0 always reads 0.
//    wb_release = wb_we_i & sb_ff[wb_rd_i].
//  - stall_o = ~rst & (hazard | state==FLUSH | jump_i). flush_o = ~rst & (jump_i | state==FLUSH).
//    Both are combinational, with the same-cycle response.
//  - Scoreboard set: issue_i & issue_ld_i & issue_rd_i!=0 & ~jump_i. Clear: wb_we_i on wb_rd_i.
//    If set and clear hit the same register in the same cycle, set wins (bit stays 1).
//  - pend_cnt: +1 on set; -1 on wb_release. If both happen in one cycle it is unchanged.
//    A writeback to a non-pending register does not decrement. pend_cnt saturates at
//    MAX_PEND and 0; a set at MAX_PEND is a simulation assertion failure.
//  - jump_i has priority over issue_i: an issue in the jump cycle is ignored.
//    A flush never clears the scoreboard, because in-flight loads still write back.
//  - FSM (registered; state_o = state_ff):
//      RUN   : jump_i->FLUSH (cnt=FLUSH_CYC-1); hazard->STALL; else RUN
//      STALL : jump_i->FLUSH; ~hazard->RUN; else STALL
//      FLUSH : jump_i->FLUSH (counter reloads); cnt!=0 -> cnt-1, stay FLUSH;
//              cnt==0 -> hazard ? STALL : RUN
//  - Latency: a hazard stalls in the same cycle it is presented. Writeback of the blocking
//    register un-stalls in the same cycle.
//  - Reset mid-operation: all state is discarded next edge; no pending writebacks are honoured.
// TESTING
//  1 Reset with all inputs=0 -> stall_o=0, flush_o=0, sb_o=0, pend_cnt_o=0, state_o=0.
//  2 Issue load rd=x5. Next cycle, fetch add using rs1=x5 -> stall_o=1, state STALL.
//    wb x5 same cycle -> stall_o=0 that cycle, sb_o[5]=0 and pend_cnt=0 next cycle.
//  3 Issue 4 loads (x1..x4), then fetch_ld_i=1 (rd=x9) -> stall_o=1, pend_cnt_o=4.
//    wb x1 -> stall_o=0 that cycle.
//  4 Issue load x7 and wb x7 in the same cycle -> sb_o[7]=1, pend_cnt unchanged
//    (+1 set, -1 release of prior x7).
//  5 jump_i with FLUSH_CYC=1 while in STALL -> flush_o=1 in the jump cycle and the next
//    cycle, and sb preserved. The cycle after that returns to RUN, or to STALL if the
//    hazard persists.
//  6 Load to x0 -> sb_o unchanged, pend_cnt unchanged. Fetch using rs1=x0 never stalls.

Source files
------------

// File: rtl/dec_hazard_ctrl.sv
// ============================================================================
// Module      : dec_hazard_ctrl
// Description : Decode-stage interlock. A load scoreboard drives RAW/WAW and
//               load-budget stalls, and a counter sequences the post-jump flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_hazard_ctrl #(
    parameter int NUM_REGS  = 32,
    parameter int MAX_PEND  = 4,
    parameter int FLUSH_CYC = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_valid_i,
    input  logic [4:0]                    fetch_rs1_i,
    input  logic [4:0]                    fetch_rs2_i,
    input  logic [4:0]                    fetch_rd_i,
    input  logic                          fetch_use_rs1_i,
    input  logic                          fetch_use_rs2_i,
    input  logic                          fetch_we_i,
    input  logic                          fetch_ld_i,
    input  logic                          issue_i,
    input  logic [4:0]                    issue_rd_i,
    input  logic                          issue_ld_i,
    input  logic                          wb_we_i,
    input  logic [4:0]                    wb_rd_i,
    input  logic                          jump_i,
    output logic                          stall_o,
    output logic                          flush_o,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt_o,
    output logic [NUM_REGS-1:0]           sb_o,
    output logic [1:0]                    state_o
);

    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [PW-1:0] c_pend_max   = PW'(MAX_PEND);
    localparam logic [PW-1:0] c_pend_one   = PW'(1);
    localparam logic [CW-1:0] c_flush_load = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] c_flush_one  = CW'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_flush_cnt;
    logic [PW-1:0]         r_pend_cnt;
    logic [NUM_REGS-1:0]   r_sb;

    logic [NUM_REGS-1:0]   w_wb_mask;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_sb_eff;
    logic                  w_wb_release;
    logic                  w_sb_set;
    logic                  w_pend_full;
    logic                  w_hazard;
    logic [PW-1:0]         w_pend_nxt;

    // x0 and indices beyond the tracked range always read as not pending.
    function automatic logic sb_bit(input logic [NUM_REGS-1:0] vec, input logic [4:0] idx);
        logic r;
        r = 1'b0;
        if ((idx != 5'd0) && (int'(idx) < NUM_REGS))
            r = vec[idx];
        return r;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [4:0] idx);
        logic [NUM_REGS-1:0] r;
        r = '0;
        if ((idx != 5'd0) && (int'(idx) < NUM_REGS))
            r[idx] = 1'b1;
        return r;
    endfunction

    always_comb begin
        w_wb_mask    = wb_we_i ? onehot(wb_rd_i) : '0;
        w_sb_eff     = r_sb & ~w_wb_mask;
        w_wb_release = wb_we_i & sb_bit(r_sb, wb_rd_i);
        w_pend_full  = (r_pend_cnt == c_pend_max);
        w_sb_set     = issue_i & issue_ld_i & (issue_rd_i != 5'd0) & ~jump_i;
        w_set_mask   = w_sb_set ? onehot(issue_rd_i) : '0;

        // A same-cycle writeback of the blocking register clears the hazard.
        w_hazard = fetch_valid_i &
                   ((fetch_use_rs1_i & sb_bit(w_sb_eff, fetch_rs1_i)) |
                    (fetch_use_rs2_i & sb_bit(w_sb_eff, fetch_rs2_i)) |
                    (fetch_we_i      & sb_bit(w_sb_eff, fetch_rd_i))  |
                    (fetch_ld_i & w_pend_full & ~w_wb_release));

        w_pend_nxt = r_pend_cnt;
        case ({w_sb_set, w_wb_release})
            2'b10: if (r_pend_cnt != c_pend_max) w_pend_nxt = r_pend_cnt + c_pend_one;
            2'b01: if (r_pend_cnt != '0)         w_pend_nxt = r_pend_cnt - c_pend_one;
            default: w_pend_nxt = r_pend_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb        <= '0;
            r_pend_cnt  <= '0;
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            // Set after clear so a same-cycle reload of a register stays pending.
            r_sb       <= (r_sb & ~w_wb_mask) | w_set_mask;
            r_pend_cnt <= w_pend_nxt;

            case (r_state)
                ST_RUN: begin
                    if (jump_i) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= c_flush_load;
                    end else if (w_hazard) begin
                        r_state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (jump_i) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= c_flush_load;
                    end else if (!w_hazard) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (jump_i) begin
                        r_flush_cnt <= c_flush_load;
                    end else if (r_flush_cnt != '0) begin
                        r_flush_cnt <= r_flush_cnt - c_flush_one;
                    end else begin
                        r_state <= w_hazard ? ST_STALL : ST_RUN;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_flush_cnt <= '0;
                end
            endcase
        end
    end

    assign stall_o    = ~rst & (w_hazard | (r_state == ST_FLUSH) | jump_i);
    assign flush_o    = ~rst & (jump_i | (r_state == ST_FLUSH));
    assign pend_cnt_o = r_pend_cnt;
    assign sb_o       = r_sb;
    assign state_o    = r_state;

    a_no_pend_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_sb_set && w_pend_full && !w_wb_release));

endmodule

`default_nettype wire
